// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: word type, frame and address layouts.
// Optional statistics counters are enabled with ICACHE_STATS_EN.
package icache_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ICACHE_NFRAMES = 16;
  localparam int unsigned ICACHE_IDX_W   = $clog2(ICACHE_NFRAMES);
  localparam int unsigned ICACHE_TAG_W   = WORD_W - 2 - ICACHE_IDX_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Counter outputs exist only when ICACHE_STATS_EN is defined.
interface icache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
`ifdef ICACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
`ifdef ICACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped frame storage: one indexed read port, one write port.
// Valid bits clear synchronously on reset; tag/data arrays are not reset.
module icache_array
  import icache_pkg::*;
#(
  parameter  int unsigned NFRAMES = ICACHE_NFRAMES,
  localparam int unsigned IDX_W   = $clog2(NFRAMES),
  localparam int unsigned TAG_W   = WORD_W - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);

  logic [NFRAMES-1:0] valid;
  logic [TAG_W-1:0]   tags [NFRAMES];
  word_t              data [NFRAMES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // A write coinciding with reset is dropped so no stale frame can become valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache with same-cycle hit and
// blocking miss fill. Define ICACHE_STATS_EN to add hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NFRAMES = ICACHE_NFRAMES
) (
  input  logic    CLK,
  input  logic    RST,
  icache_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NFRAMES);
  localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

  localparam logic [0:0] COMPARE = 1'b0;
  localparam logic [0:0] FETCH   = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  word_t            rd_data;
  logic             wr_en;
  logic             hit;

  assign idx = bus.imemaddr[2 +: IDX_W];
  assign tag = bus.imemaddr[WORD_W-1 -: TAG_W];

  icache_array #(
    .NFRAMES (NFRAMES)
  ) u_array (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (bus.iload)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= COMPARE;
    end else begin
      state <= state_next;
    end
  end

  assign hit = bus.imemREN && rd_valid && (rd_tag == tag);

  // Fill always uses the address presented in the completing cycle (redirect-safe).
  always_comb begin
    state_next   = state;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    wr_en        = 1'b0;
    case (state)
      COMPARE: begin
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = rd_data;
        end else if (bus.imemREN) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        bus.iREN = 1'b1;
        if (!bus.iwait) begin
          wr_en      = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = COMPARE;
    endcase
  end

  assign bus.iaddr = {bus.imemaddr[WORD_W-1:2], 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit) begin
        hit_count <= hit_count + 32'd1;
      end
      if ((state == COMPARE) && (state_next == FETCH)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-block instruction cache sitting between the pipelined datapath's fetch stage and the memory controller's instruction port. It serves fetch requests (imemREN, imemaddr) with a same-cycle hit response (ihit, imemload) and, on a miss, runs a fill handshake with memory (iREN, iaddr, iwait, iload) before the hit is produced. The datapath gates its PC update on ihit, so every cycle this block withholds ihit is one stall cycle in fetch.

## Interface
- NFRAMES, 16: number of cache frames; power of two, 2..256
- IDX_W, $clog2(NFRAMES): index width
- TAG_W, 30-IDX_W: tag width (addr[31:2+IDX_W])
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- imemREN  in  1  fetch request from datapath
- imemaddr  in  32  fetch byte address; word aligned, bits [1:0] ignored
- ihit  out  1  imemload valid this cycle
- imemload  out  32  instruction word
- iREN  out  1  memory read request
- iaddr  out  32  memory read address, {imemaddr[31:2],2'b00}
- iwait  in  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0
- iload  in  32  memory read data
- hit_count  out  32  present only with ICACHE_STATS_EN
- miss_count  out  32  present only with ICACHE_STATS_EN

## Operation
- Address split: offset [1:0], index [2+IDX_W-1:2], tag [31:2+IDX_W].
- Per frame: valid bit, TAG_W tag, 32-bit data.
- FSM states: COMPARE, FETCH.
- COMPARE: hit = imemREN & valid[idx] & tag[idx]==tag(imemaddr). ihit=hit, imemload=data[idx] (combinational). iREN=0. Miss with imemREN=1 -> FETCH. imemREN=0 -> stay, ihit=0.
- FETCH: iREN=1, iaddr from the current imemaddr, ihit=0. iwait=1 -> stay. iwait=0 -> write data=iload, tag, valid=1 into frame idx; -> COMPARE.
- imemREN drop while in FETCH (datapath halted): the in-flight read completes and fills; no abort of the memory handshake.
- imemaddr change while in FETCH (redirect): the fill uses the address presented in the completing cycle; the frame is written for that address only.
- Conflict miss replaces the frame unconditionally; no write-back (read-only cache).
- imemload is 0 whenever ihit=0.
- Self-modifying code is not supported; no invalidate port.

## Timing
- Reset: FSM=COMPARE, all valid=0, ihit=0, imemload=0, iREN=0, iaddr follows imemaddr, counters=0. Tag/data arrays not reset.
- Reset asserted in FETCH: state returns to COMPARE next edge, fill discarded, iREN=0 from the following cycle.
- Hit latency: 0 cycles (ihit same cycle as request).
- Miss latency: cycle 0 COMPARE miss; cycles 1..N FETCH with iREN=1 (N = memory wait cycles + 1); hit in cycle N+1. Zero-wait memory -> miss costs 2 cycles, ihit in cycle 2.
- iREN never asserted in COMPARE; at most one outstanding read.

## Configuration
- ICACHE_STATS_EN defined: hit_count increments on each cycle with ihit=1; miss_count increments on each COMPARE->FETCH transition; both wrap at 2^32, cleared by RST.
- Not defined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared package (cpu_types_pkg): word_t; new icache_frame_t struct {valid, tag, data} with ICACHE_NFRAMES constant; icachef_t address struct {tag, idx, bytoff}.
- Local enum for the FSM in the module.
- One sub-module natural: icache_array (frame storage, 1 read port keyed by index, 1 write port with write enable, synchronous valid clear on RST).

## Test plan
- Reset then imemREN=1, imemaddr=0x0000_0000, iwait=1 for 2 cycles then 0 with iload=0x2001_0005 -> iREN high 3 cycles with iaddr=0x0, ihit=1 and imemload=0x2001_0005 one cycle after fill.
- Re-read 0x0000_0000 -> ihit=1 same cycle, iREN=0, imemload=0x2001_0005.
- Conflict: fetch 0x0000_0040 (same index, NFRAMES=16) with iload=0xAAAA_AAAA -> miss and fill; then 0x0000_0000 misses again.
- Fill all 16 frames with addresses 0x00..0x3C, then read all 16 -> 16 consecutive ihit cycles, zero iREN.
- RST in the second FETCH cycle -> iREN=0 next cycle, re-fetch of same address misses.
- ICACHE_STATS_EN build: above 2-miss/1-hit sequence -> miss_count=2, hit_count=3 (including fill-following hits).
